// File: rtl/jam_cost_table_if.sv
// Lookup/load/result port bundle between the JAM and its cost-table responder.
interface jam_cost_table_if #(
    parameter int unsigned CW  = 7,
    parameter int unsigned LCW = 16
);
    logic           LoadValid;
    logic [CW-1:0]  LoadData;
    logic           LoadReady;
    logic           TableReady;
    logic [2:0]     W;
    logic [2:0]     J;
    logic [CW-1:0]  Cost;
    logic           Valid;
    logic [9:0]     MinCost;
    logic [3:0]     MatchCount;
    logic           Done;
    logic [9:0]     ResMinCost;
    logic [3:0]     ResMatchCount;
    logic [LCW-1:0] LookupCount;

    modport master (
        output LoadValid, LoadData, W, J, Valid, MinCost, MatchCount,
        input  LoadReady, TableReady, Cost, Done, ResMinCost, ResMatchCount, LookupCount
    );

    modport slave (
        input  LoadValid, LoadData, W, J, Valid, MinCost, MatchCount,
        output LoadReady, TableReady, Cost, Done, ResMinCost, ResMatchCount, LookupCount
    );
endinterface

// File: rtl/jam_cost_table.sv
// 8x8 cost table for the JAM: streamed load, 1-cycle registered lookups,
// then a one-shot capture of the JAM result.
module jam_cost_table #(
    parameter int unsigned CW  = 7,
    parameter int unsigned LCW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    jam_cost_table_if.slave bus
);
    typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [5:0]     idx_q, idx_d;
    logic [CW-1:0]  cost_q, cost_d;
    logic [LCW-1:0] lcnt_q, lcnt_d;
    logic [9:0]     resmin_q, resmin_d;
    logic [3:0]     rescnt_q, rescnt_d;
    logic           wr_en;
    logic [CW-1:0]  table_q [64];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cost_d   = cost_q;
        lcnt_d   = lcnt_q;
        resmin_d = resmin_q;
        rescnt_d = rescnt_q;
        wr_en    = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                if (bus.LoadValid) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + 6'd1;
                    if (idx_q == 6'd63) state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                cost_d = table_q[{bus.W, bus.J}];
                if (lcnt_q != '1) lcnt_d = lcnt_q + LCW'(1);
                if (bus.Valid) begin
                    resmin_d = bus.MinCost;
                    rescnt_d = bus.MatchCount;
                    state_d  = S_DONE;
                end
            end
            S_DONE: ;
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_LOAD;
            idx_q    <= '0;
            cost_q   <= '0;
            lcnt_q   <= '0;
            resmin_q <= '0;
            rescnt_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cost_q   <= cost_d;
            lcnt_q   <= lcnt_d;
            resmin_q <= resmin_d;
            rescnt_q <= rescnt_d;
        end
    end

    // Table storage deliberately survives reset; a full reload is forced by the FSM.
    always_ff @(posedge CLK) begin
        if (wr_en) table_q[idx_q] <= bus.LoadData;
    end

    assign bus.LoadReady     = (state_q == S_LOAD);
    assign bus.TableReady    = (state_q != S_LOAD);
    assign bus.Done          = (state_q == S_DONE);
    assign bus.Cost          = cost_q;
    assign bus.LookupCount   = lcnt_q;
    assign bus.ResMinCost    = resmin_q;
    assign bus.ResMatchCount = rescnt_q;
endmodule

// File: tb/tb_jam_cost_table.sv
// Directed bench for jam_cost_table; a second instance with a 2-bit lookup
// counter shadows the same stimulus to exercise counter saturation.
module tb_jam_cost_table;
    logic CLK;
    logic RST;
    int   compared   = 0;
    int   mismatched = 0;

    jam_cost_table_if #(.CW(7), .LCW(16)) bus ();
    jam_cost_table_if #(.CW(7), .LCW(2))  bus2 ();

    jam_cost_table #(.CW(7), .LCW(16)) dut  (.CLK(CLK), .RST(RST), .bus(bus));
    jam_cost_table #(.CW(7), .LCW(2))  dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

    assign bus2.LoadValid  = bus.LoadValid;
    assign bus2.LoadData   = bus.LoadData;
    assign bus2.W          = bus.W;
    assign bus2.J          = bus.J;
    assign bus2.Valid      = bus.Valid;
    assign bus2.MinCost    = bus.MinCost;
    assign bus2.MatchCount = bus.MatchCount;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b0;
        bus.LoadValid = 1'b0; bus.LoadData = '0; bus.W = '0; bus.J = '0;
        bus.Valid = 1'b0; bus.MinCost = '0; bus.MatchCount = '0;

        // Asynchronous reset mid-cycle
        #3 RST = 1'b1;
        #1;
        chk("rst_loadready", 32'(bus.LoadReady), 1);
        chk("rst_tableready", 32'(bus.TableReady), 0);
        chk("rst_cost", 32'(bus.Cost), 0);
        chk("rst_done", 32'(bus.Done), 0);
        chk("rst_lcnt", 32'(bus.LookupCount), 0);
        chk("rst_resmin", 32'(bus.ResMinCost), 0);
        chk("rst_rescnt", 32'(bus.ResMatchCount), 0);
        tick();
        RST = 1'b0;

        // Full load k mod 100, LoadValid held high
        for (int k = 0; k < 64; k++) begin
            bus.LoadValid = 1'b1;
            bus.LoadData  = 7'(k % 100);
            tick();
            if (k == 62) chk("load63_tableready", 32'(bus.TableReady), 0);
        end
        bus.LoadValid = 1'b0;
        chk("load_tableready", 32'(bus.TableReady), 1);
        chk("load_loadready", 32'(bus.LoadReady), 0);
        chk("load_cost_zero", 32'(bus.Cost), 0);
        chk("load_lcnt_zero", 32'(bus.LookupCount), 0);

        bus.W = 3'd3; bus.J = 3'd5; tick();
        chk("cost_3_5", 32'(bus.Cost), 29);
        chk("lcnt_1", 32'(bus.LookupCount), 1);
        bus.W = 3'd7; bus.J = 3'd7; tick();
        chk("cost_7_7", 32'(bus.Cost), 63);
        chk("lcnt_2", 32'(bus.LookupCount), 2);

        // Back-to-back sweep; LoadValid in SERVE must not write
        bus.W = 3'd0; bus.J = 3'd0; bus.LoadValid = 1'b1; bus.LoadData = 7'd99; tick();
        bus.LoadValid = 1'b0;
        chk("cost_0_0", 32'(bus.Cost), 0);
        chk("lcnt_3", 32'(bus.LookupCount), 3);
        bus.W = 3'd1; bus.J = 3'd2; tick();
        chk("cost_1_2", 32'(bus.Cost), 10);
        chk("lcnt_4", 32'(bus.LookupCount), 4);
        bus.W = 3'd2; bus.J = 3'd4; tick();
        chk("cost_2_4", 32'(bus.Cost), 20);
        chk("lcnt_5", 32'(bus.LookupCount), 5);
        chk("lcnt2_sat_5", 32'(bus2.LookupCount), 3);
        bus.W = 3'd0; bus.J = 3'd0; tick();
        chk("cost_0_0_nowrite", 32'(bus.Cost), 0);
        chk("lcnt_6", 32'(bus.LookupCount), 6);
        chk("lcnt2_sat_6", 32'(bus2.LookupCount), 3);

        // Result capture
        bus.W = 3'd7; bus.J = 3'd7; bus.MinCost = 10'd123; bus.MatchCount = 4'd2; bus.Valid = 1'b1;
        chk("pre_done", 32'(bus.Done), 0);
        tick();
        chk("done", 32'(bus.Done), 1);
        chk("resmin", 32'(bus.ResMinCost), 123);
        chk("rescnt", 32'(bus.ResMatchCount), 2);
        chk("cost_on_valid", 32'(bus.Cost), 63);
        chk("lcnt_7", 32'(bus.LookupCount), 7);

        // DONE holds against all inputs
        bus.W = 3'd1; bus.J = 3'd2; bus.MinCost = 10'd5; bus.MatchCount = 4'd9;
        bus.LoadValid = 1'b1; bus.Valid = 1'b1;
        tick(); tick(); tick();
        chk("done_cost_hold", 32'(bus.Cost), 63);
        chk("done_lcnt_hold", 32'(bus.LookupCount), 7);
        chk("done_resmin_hold", 32'(bus.ResMinCost), 123);
        chk("done_rescnt_hold", 32'(bus.ResMatchCount), 2);
        chk("done_hold", 32'(bus.Done), 1);
        chk("done_tableready", 32'(bus.TableReady), 1);
        chk("done_loadready", 32'(bus.LoadReady), 0);
        bus.LoadValid = 1'b0; bus.Valid = 1'b0;

        // Reset out of DONE
        #2 RST = 1'b1;
        #1;
        chk("rst2_loadready", 32'(bus.LoadReady), 1);
        chk("rst2_done", 32'(bus.Done), 0);
        chk("rst2_cost", 32'(bus.Cost), 0);
        chk("rst2_lcnt", 32'(bus.LookupCount), 0);
        tick();
        RST = 1'b0;

        // Gapped partial load of 30, with Valid held high (ignored in LOAD)
        bus.Valid = 1'b1; bus.MinCost = 10'd77; bus.MatchCount = 4'd7;
        for (int a = 0; a < 30; a++) begin
            bus.LoadValid = 1'b0; tick();
            bus.LoadValid = 1'b1; bus.LoadData = 7'((a * 3 + 1) % 128); tick();
        end
        bus.LoadValid = 1'b0;
        #2 RST = 1'b1;
        #2 RST = 1'b0;
        chk("midload_rst_loadready", 32'(bus.LoadReady), 1);

        // Gapped full reload of 127-a
        for (int a = 0; a < 64; a++) begin
            bus.LoadValid = 1'b0; tick();
            bus.LoadValid = 1'b1; bus.LoadData = 7'(127 - a); tick();
            if (a == 33) chk("accept34_tableready", 32'(bus.TableReady), 0);
            if (a == 62) chk("accept63_tableready", 32'(bus.TableReady), 0);
        end
        bus.LoadValid = 1'b0; bus.Valid = 1'b0;
        chk("reload_tableready", 32'(bus.TableReady), 1);
        chk("reload_done", 32'(bus.Done), 0);
        chk("reload_resmin", 32'(bus.ResMinCost), 0);
        chk("reload_cost", 32'(bus.Cost), 0);

        bus.W = 3'd1; bus.J = 3'd0; tick();
        chk("gapped_cost_1_0", 32'(bus.Cost), 119);
        bus.W = 3'd3; bus.J = 3'd5; tick();
        chk("gapped_cost_3_5", 32'(bus.Cost), 98);
        chk("gapped_lcnt", 32'(bus.LookupCount), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
